// File: rtl/adc_stream_depacker_if.sv
// AXI-Stream style bus used on both sides of the ADC stream depacker.
// Byte side: DATA_W=8, KEEP_W=1. Word side: DATA_W=W*channels, KEEP_W=channels.
interface adc_stream_depacker_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KEEP_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/adc_stream_depacker.sv
// Rebuilds one multi-channel ADC word per packet from the packed 8-bit byte stream.
// Define ADC_DEPACK_ERRCNT_EN to add a saturating 16-bit discarded-packet counter o_err_cnt.
module adc_stream_depacker #(
    parameter int unsigned ADC_NUM_CHANNELS = 4,
    parameter int unsigned ADC_CHN_WIDTH    = 14,
    parameter int unsigned ADC_CHN_BYTES    = (ADC_CHN_WIDTH + 7) / 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [ADC_NUM_CHANNELS-1:0] i_chn_en,
    adc_stream_depacker_if.slave        s_axis,
    adc_stream_depacker_if.master       m_axis,
`ifdef ADC_DEPACK_ERRCNT_EN
    output logic [15:0]                 o_err_cnt,
`endif
    output logic                        o_err
);
    localparam int unsigned PAD     = ADC_CHN_BYTES * 8 - ADC_CHN_WIDTH;
    localparam int unsigned SLOT_W  = ADC_CHN_BYTES * 8;
    localparam int unsigned STAGE_W = ADC_NUM_CHANNELS * SLOT_W;
    localparam int unsigned DW      = ADC_NUM_CHANNELS * ADC_CHN_WIDTH;
    localparam int unsigned CNT_W   = $clog2(ADC_NUM_CHANNELS * ADC_CHN_BYTES + 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrop, StEmit} state_e;

    state_e                      state_q;
    logic [ADC_NUM_CHANNELS-1:0] mask_q, mask_use;
    logic [CNT_W-1:0]            cnt_q, cnt_use, cnt_inc, nexp;
    logic [STAGE_W-1:0]          stage_q, stage_use;
    logic [SLOT_W-1:0]           slot;
    logic [DW-1:0]               word;
    logic [DW-1:0]               m_tdata_q;
    logic [ADC_NUM_CHANNELS-1:0] m_tkeep_q;
    logic                        m_tvalid_q;
    logic                        err_q;
    logic                        beat;
    logic                        overflow;
    int                          rank;

    assign s_axis.tready = (state_q != StEmit) && !(m_tvalid_q && !m_axis.tready);
    assign beat          = s_axis.tvalid && s_axis.tready;

    // The first beat of a packet sees a fresh mask, counter and staging register.
    always_comb begin
        mask_use  = (state_q == StIdle) ? i_chn_en : mask_q;
        cnt_use   = (state_q == StIdle) ? '0 : cnt_q;
        stage_use = (state_q == StIdle) ? '0 : stage_q;
        nexp      = '0;
        rank      = 0;
        slot      = '0;
        word      = '0;
        for (int i = 0; i < ADC_NUM_CHANNELS; i++) begin
            if (mask_use[i]) nexp = nexp + CNT_W'(ADC_CHN_BYTES);
        end
        overflow = s_axis.tkeep[0] && (cnt_use == nexp);
        cnt_inc  = cnt_use;
        if (s_axis.tkeep[0] && !overflow) begin
            cnt_inc = cnt_use + CNT_W'(1);
            // Byte cnt lands in the (cnt / BYTES)-th enabled channel, lane cnt % BYTES.
            for (int i = 0; i < ADC_NUM_CHANNELS; i++) begin
                if (mask_use[i]) begin
                    for (int b = 0; b < ADC_CHN_BYTES; b++) begin
                        if (cnt_use == CNT_W'(rank * ADC_CHN_BYTES + b)) begin
                            stage_use[(i * ADC_CHN_BYTES + b) * 8 +: 8] = s_axis.tdata;
                        end
                    end
                    rank = rank + 1;
                end
            end
        end
        for (int i = 0; i < ADC_NUM_CHANNELS; i++) begin
            slot = stage_use[i * SLOT_W +: SLOT_W] >> PAD;
            word[i * ADC_CHN_WIDTH +: ADC_CHN_WIDTH] =
                mask_use[i] ? slot[ADC_CHN_WIDTH-1:0] : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            cnt_q      <= '0;
            stage_q    <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle, StCollect: begin
                    if (beat) begin
                        mask_q  <= mask_use;
                        stage_q <= stage_use;
                        cnt_q   <= cnt_inc;
                        if (overflow) begin
                            // An overflowing tlast beat already ends the packet.
                            err_q   <= 1'b1;
                            state_q <= s_axis.tlast ? StIdle : StDrop;
                        end else if (s_axis.tlast) begin
                            if (cnt_inc == nexp) begin
                                m_tdata_q  <= word;
                                m_tkeep_q  <= mask_use;
                                m_tvalid_q <= 1'b1;
                                state_q    <= StEmit;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else begin
                            state_q <= StCollect;
                        end
                    end
                end
                StDrop: begin
                    if (beat && s_axis.tlast) state_q <= StIdle;
                end
                StEmit: begin
                    if (m_axis.tready) begin
                        m_tvalid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = 1'b1;
    assign o_err         = err_q;

`ifdef ADC_DEPACK_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_q <= '0;
        end else if (err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif
endmodule
